ram_dma_controller: RTL and testbench
=====================================

# ram_dma_controller

Sequential block-transfer engine sitting directly upstream of RAM256x64. It moves a run of 64-bit words between a valid/ready stream port and consecutive RAM addresses, either filling RAM from an input stream or dumping RAM to an output stream. It owns the RAM's address, in and ramWrite pins and consumes its out bus, so the rest of the processor sees a simple start/done transfer interface.

## Interface
- No parameters; widths fixed to RAM256x64: 8-bit address, 64-bit data.
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin transfer; sampled only in IDLE
- mode  in  1  0 = fill (stream to RAM), 1 = dump (RAM to stream); sampled with start
- baseAddr  in  8  first RAM address; sampled with start
- length  in  9  word count 0..256; sampled with start
- inData  in  64  fill stream data
- inValid  in  1  fill stream valid
- inReady  out  1  fill stream ready
- outData  out  64  dump stream data
- outValid  out  1  dump stream valid
- outReady  in  1  dump stream ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of transfer
- ramAddress  out  8  to RAM256x64 address
- ramIn  out  64  to RAM256x64 in
- ramWrite  out  1  to RAM256x64 ramWrite
- ramOut  in  64  from RAM256x64 out

## Operation
- States: IDLE, WRITE, FLUSH, RD_ADDR, RD_CAPT, RD_HOLD, DONE.
- Internal: ptr (8 bit), remaining (9 bit).
- IDLE: on start, ptr = baseAddr, remaining = length. length 0 -> DONE; mode 0 -> WRITE; mode 1 -> RD_ADDR, with ramAddress = baseAddr loaded on the same edge.
- WRITE: inReady = 1. On inValid & inReady: next cycle ramWrite = 1, ramAddress = ptr, ramIn = inData; ptr++, remaining--. If remaining was 1 -> FLUSH, else stay in WRITE.
- FLUSH: one cycle in which the last write is on the RAM pins; inReady = 0; -> DONE.
- ramWrite is registered and is 1 only in the cycle after a fill handshake; otherwise 0. ramIn and ramAddress hold their last value when not updated.
- RD_ADDR: ramAddress = ptr is on the RAM pins; -> RD_CAPT.
- RD_CAPT: RAM read is synchronous, so ramOut is valid here; outData <= ramOut at end of cycle; -> RD_HOLD.
- RD_HOLD: outValid = 1, outData stable until outReady. On handshake: ptr++, remaining--. If remaining was 1 -> DONE. Otherwise -> RD_ADDR with ramAddress = ptr+1.
- DONE: done = 1 for exactly one cycle, busy still 1; -> IDLE.
- Address arithmetic is mod 256: ptr 0xFF increments to 0x00. length 256 covers every location exactly once.
- start, mode, baseAddr and length are ignored outside IDLE.
- inReady is never 1 in dump mode, and outValid is never 1 in fill mode.

## Timing
- Reset values: state IDLE, ramAddress 0, ramIn 0, ramWrite 0, outData 0, outValid 0, inReady 0, busy 0, done 0, ptr 0, remaining 0.
- Reset mid-transfer aborts immediately. ramWrite is 0 on the cycle after reset asserts, and no further RAM write occurs.
- Fill latency: start at cycle T -> inReady at T+1. Handshake at cycle k -> RAM write at k+1. Last handshake at k -> FLUSH at k+1, done at k+2, IDLE at k+3.
- Fill throughput is 1 word per cycle with inValid held high.
- Dump: start at T -> RD_ADDR T+1, RD_CAPT T+2, outValid T+3. Throughput is 1 word per 3 cycles with outReady held high. Last handshake at k -> done at k+1.
- length 0: start at T -> done at T+1, with no RAM or stream activity.
- inReady and outValid are decoded from the state register, not from same-cycle inputs.

## Test plan
- Fill with wrap: baseAddr 0xFE, length 4, words A,B,C,D streamed back-to-back. Required: ramWrite high 4 consecutive cycles at addresses FE, FF, 00, 01; done exactly 2 cycles after the last handshake.
- Dump with backpressure: after the fill, dump from baseAddr 0xFE, length 4, with outReady toggling 1-in-3 cycles. Required: outData sequence A,B,C,D, each held stable while outValid=1 and outReady=0; ramWrite stays 0 throughout.
- length 0 in both modes: done at T+1, busy high for one cycle only, inReady and outValid never assert.
- start pulsed at cycle 3 of an active fill, with a different baseAddr. Required: ignored; the transfer completes at the original addresses.
- Reset asserted after 2 of 5 fill words. Required: next cycle all outputs at reset values; no write occurs to the third address; a new fill started after reset completes normally.
- Full sweep: fill with length 256 from baseAddr 0x80, writing value = address, then dump length 256 from 0x00. Required: every outData equals its address, and done pulses once per transfer.

Source files
------------

// File: rtl/ram_dma_controller.sv
// Block-transfer engine between a valid/ready stream and a 256x64 synchronous RAM.
// Fill mode streams words into consecutive RAM addresses; dump mode streams them back out.
// Addresses wrap modulo 256, so a 256-word transfer touches every location exactly once.
module ram_dma_controller (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        mode_i,
    input  logic [7:0]  base_addr_i,
    input  logic [8:0]  length_i,
    input  logic [63:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [63:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  ram_address_o,
    output logic [63:0] ram_in_o,
    output logic        ram_write_o,
    input  logic [63:0] ram_out_i
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StFlush,
        StRdAddr,
        StRdCapt,
        StRdHold,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [7:0]  ram_address_q, ram_address_d;
    logic [63:0] ram_in_q, ram_in_d;
    logic        ram_write_q, ram_write_d;
    logic [63:0] out_data_q, out_data_d;

    // State register with synchronous abort on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; start and its qualifiers only matter in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (length_i == 9'd0) begin
                        state_d = StDone;
                    end else if (mode_i) begin
                        state_d = StRdAddr;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (in_valid_i && (remaining_q == 9'd1)) begin
                    state_d = StFlush;
                end
            end
            StFlush:  state_d = StDone;
            StRdAddr: state_d = StRdCapt;
            StRdCapt: state_d = StRdHold;
            StRdHold: begin
                if (out_ready_i) begin
                    state_d = (remaining_q == 9'd1) ? StDone : StRdAddr;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state: pointer/count bookkeeping and the registered RAM pins.
    always_comb begin
        ptr_d         = ptr_q;
        remaining_d   = remaining_q;
        ram_address_d = ram_address_q;
        ram_in_d      = ram_in_q;
        ram_write_d   = 1'b0;
        out_data_d    = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    ptr_d       = base_addr_i;
                    remaining_d = length_i;
                    // Present the first read address while moving into RD_ADDR.
                    if (mode_i && (length_i != 9'd0)) begin
                        ram_address_d = base_addr_i;
                    end
                end
            end
            StWrite: begin
                // in_ready is high throughout this state, so in_valid alone is the handshake.
                if (in_valid_i) begin
                    ram_write_d   = 1'b1;
                    ram_address_d = ptr_q;
                    ram_in_d      = in_data_i;
                    ptr_d         = ptr_q + 8'd1;
                    remaining_d   = remaining_q - 9'd1;
                end
            end
            StRdCapt: begin
                out_data_d = ram_out_i;
            end
            StRdHold: begin
                if (out_ready_i) begin
                    ptr_d       = ptr_q + 8'd1;
                    remaining_d = remaining_q - 9'd1;
                    if (remaining_q != 9'd1) begin
                        ram_address_d = ptr_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q         <= 8'd0;
            remaining_q   <= 9'd0;
            ram_address_q <= 8'd0;
            ram_in_q      <= 64'd0;
            ram_write_q   <= 1'b0;
            out_data_q    <= 64'd0;
        end else begin
            ptr_q         <= ptr_d;
            remaining_q   <= remaining_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            ram_write_q   <= ram_write_d;
            out_data_q    <= out_data_d;
        end
    end

    // Handshake and status outputs decode purely from the state register.
    always_comb begin
        in_ready_o    = (state_q == StWrite);
        out_valid_o   = (state_q == StRdHold);
        busy_o        = (state_q != StIdle);
        done_o        = (state_q == StDone);
        out_data_o    = out_data_q;
        ram_address_o = ram_address_q;
        ram_in_o      = ram_in_q;
        ram_write_o   = ram_write_q;
    end

endmodule

// File: tb/tb_ram_dma_controller.sv
// Scoreboard bench for ram_dma_controller: stimulus pushes expected RAM writes, stream words
// and done cycles into queues; an independent negedge monitor pops and compares them.
module tb_ram_dma_controller;

    logic        clk = 1'b0;
    logic        reset, start, mode;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic [63:0] in_data;
    logic        in_valid, in_ready;
    logic [63:0] out_data;
    logic        out_valid, out_ready;
    logic        busy, done;
    logic [7:0]  ram_address;
    logic [63:0] ram_in;
    logic        ram_write;
    logic [63:0] ram_out;

    always #5 clk = ~clk;

    ram_dma_controller dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .mode_i       (mode),
        .base_addr_i  (base_addr),
        .length_i     (length),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy),
        .done_o       (done),
        .ram_address_o(ram_address),
        .ram_in_o     (ram_in),
        .ram_write_o  (ram_write),
        .ram_out_i    (ram_out)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [63:0] out_q[$];
    int          done_q[$];
    logic [63:0] words[$];
    logic [63:0] mem[256];
    logic [63:0] ref_mem[256];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          fill_expect_ready = 1'b0;

    function automatic logic [63:0] init_val(input int i);
        return {32'hA5A5_0000 + 32'(i), 32'(i) ^ 32'h5A5A_F00D};
    endfunction

    // Behavioural RAM256x64: synchronous write and registered read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (ram_write) begin
            mem[ram_address] <= ram_in;
        end
        ram_out <= mem[ram_address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: every visible RAM write, stream word and done pulse must match the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (ram_write === 1'b1) begin
            if (wr_q.size() == 0) begin
                fail("unexpected_ram_write");
            end else begin
                e = wr_q.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                chk("wr_addr", 64'(ram_address), 64'(e.addr));
                chk("wr_data", ram_in, e.data);
            end
        end
        if (out_valid === 1'b1) begin
            if (out_q.size() == 0) begin
                fail("unexpected_out_valid");
            end else begin
                chk("out_data", out_data, out_q[0]);
                if (out_ready) void'(out_q.pop_front());
            end
        end
        if (in_ready === 1'b1 && !fill_expect_ready) fail("unexpected_in_ready");
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                fail("unexpected_done");
            end else begin
                chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                chk("busy_at_done", 64'(busy), 64'd1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_address"}, 64'(ram_address), 64'd0);
        chk({tag, "_ram_in"}, ram_in, 64'd0);
        chk({tag, "_ram_write"}, 64'(ram_write), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (done_q.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (done_q.size() != 0) begin
            fail("done_timeout");
            done_q.delete();
        end
        @(posedge clk); #1;
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic do_fill(input logic [7:0] base, input int len, input int gap_pct,
                           input int glitch_at, input int abort_after);
        int          t, idx, guard;
        logic [7:0]  a;
        wr_t         e;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base_addr = base; length = 9'(len);
        t = cyc;
        if (len == 0) done_q.push_back(t + 1);
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); base_addr = 8'($urandom); length = 9'($urandom);
        chk("fill_in_ready_latency", 64'(in_ready), (len != 0) ? 64'd1 : 64'd0);
        if (len == 0) begin
            chk("len0_fill_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
            chk("len0_fill_busy_off", 64'(busy), 64'd0);
            return;
        end
        fill_expect_ready = 1'b1;
        idx = 0;
        guard = 0;
        while (idx < len) begin
            in_valid = (int'($urandom_range(99)) >= gap_pct);
            in_data = words[idx];
            if (cyc - t == glitch_at) begin
                start = 1'b1; mode = 1'b1; base_addr = base ^ 8'h5A; length = 9'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                a = base + 8'(idx);
                e.cyc = cyc + 1; e.addr = a; e.data = words[idx];
                wr_q.push_back(e);
                ref_mem[a] = words[idx];
                idx++;
                if (idx == len) done_q.push_back(cyc + 2);
            end
            guard++;
            if (guard > 1000) begin
                fail("fill_timeout");
                break;
            end
            if (idx == abort_after) begin
                // Reset lands while the last accepted word is on the RAM pins.
                @(posedge clk); #1;
                reset = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = words[idx];
                @(posedge clk); #1;
                reset = 1'b0; in_valid = 1'b0; fill_expect_ready = 1'b0;
                check_reset_outputs("abort");
                a = base + 8'(idx);
                chk("no_write_after_reset", mem[a], ref_mem[a]);
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start = 1'b0;
        fill_expect_ready = 1'b0;
        wait_idle();
    endtask

    // rdy_mode: 0 = outReady held high, 1 = high one cycle in three, else random.
    task automatic do_dump(input logic [7:0] base, input int len, input int rdy_mode);
        int         t, hs, guard;
        bit         seen;
        logic [7:0] a;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; base_addr = base; length = 9'(len);
        t = cyc;
        if (len == 0) done_q.push_back(t + 1);
        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            out_q.push_back(ref_mem[a]);
        end
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); base_addr = 8'($urandom); length = 9'($urandom);
        chk("dump_in_ready", 64'(in_ready), 64'd0);
        if (len == 0) begin
            chk("len0_dump_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
            chk("len0_dump_busy_off", 64'(busy), 64'd0);
            return;
        end
        hs = 0;
        guard = 0;
        seen = 1'b0;
        while (hs < len) begin
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom);
            endcase
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                chk("first_out_valid_cycle", 64'(cyc), 64'(t + 3));
            end
            if (out_valid && out_ready) begin
                if (rdy_mode == 0) chk("dump_handshake_cycle", 64'(cyc), 64'(t + 3 + 3 * hs));
                hs++;
                if (hs == len) done_q.push_back(cyc + 1);
            end
            guard++;
            if (guard > 5000) begin
                fail("dump_timeout");
                out_q.delete();
                break;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         n;
        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = 8'd0; length = 9'd0;
        in_data = 64'd0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Fill across the address wrap, then read back with backpressure.
        words.delete();
        words.push_back(64'hAAAA_AAAA_0000_000A);
        words.push_back(64'hBBBB_BBBB_0000_000B);
        words.push_back(64'hCCCC_CCCC_0000_000C);
        words.push_back(64'hDDDD_DDDD_0000_000D);
        do_fill(8'hFE, 4, 0, -1, -1);
        do_dump(8'hFE, 4, 1);

        // Zero-length transfers in both modes.
        do_fill(8'h33, 0, 0, -1, -1);
        do_dump(8'h44, 0, 0);

        // start re-asserted mid-fill must be ignored.
        words.delete();
        for (int j = 0; j < 6; j++) words.push_back({$urandom, $urandom});
        do_fill(8'h40, 6, 0, 3, -1);
        do_dump(8'h40, 6, 0);

        // Reset after two of five words, then a clean refill and readback.
        words.delete();
        for (int j = 0; j < 5; j++) words.push_back({$urandom, $urandom});
        do_fill(8'h10, 5, 0, -1, 2);
        words.delete();
        for (int j = 0; j < 5; j++) words.push_back({$urandom, $urandom});
        do_fill(8'h10, 5, 20, -1, -1);
        do_dump(8'h10, 5, 2);

        // Random transfers with stream gaps and random backpressure.
        for (int r = 0; r < 8; r++) begin
            b = 8'($urandom);
            n = int'($urandom_range(1, 20));
            if (r % 2 == 0) begin
                words.delete();
                for (int j = 0; j < n; j++) words.push_back({$urandom, $urandom});
                do_fill(b, n, 30, -1, -1);
            end else begin
                do_dump(b, n, 2);
            end
        end

        // Full sweep: every location written with its own address, then read back.
        words.delete();
        for (int j = 0; j < 256; j++) words.push_back(64'((128 + j) % 256));
        do_fill(8'h80, 256, 0, -1, -1);
        do_dump(8'h00, 256, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        chk("out_queue_drained", 64'(out_q.size()), 64'd0);
        chk("done_queue_drained", 64'(done_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
